// File: rtl/fifo2pcie.sv
// fifo2pcie: TX-side reader that drains the TX TLP FIFO into the PCIe core's
// 64-bit s_axis_tx AXI-stream.
//
// Each FIFO read returns one entry a cycle later. Bubble entries are skipped.
// A packet is dropped when the link is down at its first beat, or when it is
// only one beat long (too short to be a valid TLP). Kept beats go into a
// small output queue, so core backpressure never loses a beat.
//
// Ports
//   pcie_clk, pcie_rst      clock, synchronous active-high reset
//   rd_en                   FIFO read strobe (data on dout_* next cycle)
//   empty                   FIFO empty
//   dout_data_valid         1 = real beat, 0 = bubble entry
//   dout_tlast/tkeep/tdata  FIFO read data
//   user_lnk_up             PCIe link status
//   pcie_tx_*               AXI-stream toward the PCIe core (tuser tied 0)
//   tx_pkt_cnt              TLPs accepted by the core (wraps)
//   drop_cnt                TLPs dropped (saturates)
module fifo2pcie #(
  parameter int OBUF_DEPTH = 4,
  parameter int DROP_CNT_W = 16
) (
  input  logic                  pcie_clk,
  input  logic                  pcie_rst,
  output logic                  rd_en,
  input  logic                  empty,
  input  logic                  dout_data_valid,
  input  logic                  dout_tlast,
  input  logic [7:0]            dout_tkeep,
  input  logic [63:0]           dout_tdata,
  input  logic                  user_lnk_up,
  input  logic                  pcie_tx_tready,
  output logic                  pcie_tx_tvalid,
  output logic                  pcie_tx_tlast,
  output logic [7:0]            pcie_tx_tkeep,
  output logic [63:0]           pcie_tx_tdata,
  output logic [3:0]            pcie_tx_tuser,
  output logic [31:0]           tx_pkt_cnt,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PKT   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // queue entry layout: {tlast, tkeep, tdata}
  localparam int ENT_W = 73;

  logic [2:0]            occ_q, occ_d;
  logic                  pend_q, pend_d;
  logic [1:0]            state_q, state_d;
  logic [1:0]            wr_ptr_q, wr_ptr_d;
  logic [1:0]            rd_ptr_q, rd_ptr_d;
  logic [ENT_W-1:0]      mem_q [OBUF_DEPTH];
  logic [ENT_W-1:0]      mem_d [OBUF_DEPTH];
  logic [31:0]           pkt_cnt_q, pkt_cnt_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic                  push_s;
  logic                  pop_s;
  logic                  drop_s;
  logic [ENT_W-1:0]      head_s;

  // Stop issuing reads once queued plus in-flight beats reach 3. The queue
  // then always has room for the beat still in flight, so it cannot overflow.
  // Reads are also held off during reset so no FIFO entry is lost.
  assign rd_en = !pcie_rst && !empty && ((occ_q + {2'b00, pend_q}) <= 3'd2);

  assign head_s         = mem_q[rd_ptr_q];
  assign pcie_tx_tvalid = (occ_q != 3'd0);
  assign pcie_tx_tlast  = head_s[72];
  assign pcie_tx_tkeep  = head_s[71:64];
  assign pcie_tx_tdata  = head_s[63:0];
  assign pcie_tx_tuser  = 4'b0000;
  assign tx_pkt_cnt     = pkt_cnt_q;
  assign drop_cnt       = drop_cnt_q;

  assign pop_s = pcie_tx_tvalid && pcie_tx_tready;

  // Classify the beat returned by last cycle's read: push, discard or drop.
  always_comb begin
    push_s  = 1'b0;
    drop_s  = 1'b0;
    state_d = state_q;
    if (pend_q && dout_data_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (!user_lnk_up) begin
            // Discard the rest of this packet unless it ends here.
            drop_s  = 1'b1;
            state_d = dout_tlast ? ST_IDLE : ST_DRAIN;
          end else if (dout_tlast) begin
            // One-beat TLP cannot hold even a 3DW header.
            drop_s  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            push_s  = 1'b1;
            state_d = ST_PKT;
          end
        end
        ST_PKT: begin
          // A packet already started is always finished, link or not.
          push_s  = 1'b1;
          state_d = dout_tlast ? ST_IDLE : ST_PKT;
        end
        ST_DRAIN: begin
          state_d = dout_tlast ? ST_IDLE : ST_DRAIN;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Next state for the output queue storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    pend_d   = rd_en;
    if (push_s) begin
      mem_d[wr_ptr_q] = {dout_tlast, dout_tkeep, dout_tdata};
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   occ_d = occ_q + 3'd1;
      2'b01:   occ_d = occ_q - 3'd1;
      default: occ_d = occ_q;
    endcase
  end

  // Next state for the packet counter (wraps) and drop counter (saturates).
  always_comb begin
    pkt_cnt_d  = pkt_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (pop_s && head_s[72]) begin
      pkt_cnt_d = pkt_cnt_q + 32'd1;
    end else begin
      pkt_cnt_d = pkt_cnt_q;
    end
    if (drop_s && (drop_cnt_q != {DROP_CNT_W{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + {{(DROP_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // State registers.
  always_ff @(posedge pcie_clk) begin
    if (pcie_rst) begin
      occ_q      <= 3'd0;
      pend_q     <= 1'b0;
      state_q    <= ST_IDLE;
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      pkt_cnt_q  <= 32'd0;
      drop_cnt_q <= {DROP_CNT_W{1'b0}};
      for (int i = 0; i < OBUF_DEPTH; i++) begin
        mem_q[i] <= {ENT_W{1'b0}};
      end
    end else begin
      occ_q      <= occ_d;
      pend_q     <= pend_d;
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      for (int i = 0; i < OBUF_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: tb/tb_fifo2pcie.sv
// Self-checking bench for fifo2pcie. A behavioural FIFO with read latency 1
// feeds the DUT. Each transmitted beat is captured and compared against
// packets the bench built itself. A table of packet scenarios runs first,
// followed by hand-written sequences for latency, backpressure, counter
// saturation and reset in the middle of a packet.
module tb_fifo2pcie;

  logic        pcie_clk;
  logic        pcie_rst;
  logic        rd_en;
  logic        empty;
  logic        dout_data_valid;
  logic        dout_tlast;
  logic [7:0]  dout_tkeep;
  logic [63:0] dout_tdata;
  logic        user_lnk_up;
  logic        pcie_tx_tready;
  logic        pcie_tx_tvalid;
  logic        pcie_tx_tlast;
  logic [7:0]  pcie_tx_tkeep;
  logic [63:0] pcie_tx_tdata;
  logic [3:0]  pcie_tx_tuser;
  logic [31:0] tx_pkt_cnt;
  logic [15:0] drop_cnt;

  fifo2pcie #(.OBUF_DEPTH(4), .DROP_CNT_W(16)) dut (
    .pcie_clk(pcie_clk), .pcie_rst(pcie_rst), .rd_en(rd_en), .empty(empty),
    .dout_data_valid(dout_data_valid), .dout_tlast(dout_tlast),
    .dout_tkeep(dout_tkeep), .dout_tdata(dout_tdata), .user_lnk_up(user_lnk_up),
    .pcie_tx_tready(pcie_tx_tready), .pcie_tx_tvalid(pcie_tx_tvalid),
    .pcie_tx_tlast(pcie_tx_tlast), .pcie_tx_tkeep(pcie_tx_tkeep),
    .pcie_tx_tdata(pcie_tx_tdata), .pcie_tx_tuser(pcie_tx_tuser),
    .tx_pkt_cnt(tx_pkt_cnt), .drop_cnt(drop_cnt)
  );

  initial pcie_clk = 1'b0;
  always #5 pcie_clk = ~pcie_clk;

  typedef struct packed {
    logic        v;
    logic        last;
    logic [7:0]  keep;
    logic [63:0] data;
  } fent_t;

  typedef struct packed {
    logic        last;
    logic [7:0]  keep;
    logic [63:0] data;
  } beat_t;

  // One packet scenario. lnk_mode: 0 = link down, 1 = up, 2 = drops after beat 1.
  typedef struct {
    int beats;
    int lnk_mode;
    bit bubbles;
    bit exp_tx;
    int exp_drop;
  } vec_t;

  fent_t fq[$];
  beat_t got[$];
  int    checks;
  int    errors;
  int    rd_cnt;
  int    cyc;
  int    first_rd;
  int    first_v;
  int    real_pops;
  bit    rd_pending;
  bit    lnk_mode2;
  int    exp_pkt;
  int    exp_drop;
  vec_t  tv[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mk_data(input int v, input int b);
    logic [7:0] vb;
    logic [7:0] bb;
    vb = 8'(v);
    bb = 8'(b);
    return {16'hBEEF, vb, bb, 32'h1234_5678 ^ 32'(v * 37 + b)};
  endfunction

  function automatic logic [7:0] mk_keep(input int beats, input int b);
    return ((b == beats - 1) && (beats > 2)) ? 8'h0F : 8'hFF;
  endfunction

  task automatic push_pkt(input int v, input int beats, input bit bubbles);
    fent_t e;
    for (int b = 0; b < beats; b++) begin
      e.v = 1'b1;
      e.last = (b == beats - 1);
      e.keep = mk_keep(beats, b);
      e.data = mk_data(v, b);
      fq.push_back(e);
      if (bubbles) begin
        // Bubble carries tlast=1 and junk so that mishandling it is visible.
        e.v = 1'b0;
        e.last = 1'b1;
        e.keep = 8'h00;
        e.data = 64'hDEAD_DEAD_DEAD_DEAD;
        fq.push_back(e);
      end
    end
  endtask

  // One clock: sample rd_en and the handshake between edges, then model the
  // FIFO returning the requested entry after the rising edge.
  task automatic tick();
    fent_t e;
    beat_t bt;
    empty = (fq.size() == 0);
    #1;
    rd_pending = rd_en;
    if (rd_en) begin
      rd_cnt++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (pcie_tx_tvalid && first_v < 0) first_v = cyc;
    if (pcie_tx_tvalid && pcie_tx_tready) begin
      bt.last = pcie_tx_tlast;
      bt.keep = pcie_tx_tkeep;
      bt.data = pcie_tx_tdata;
      got.push_back(bt);
    end
    @(posedge pcie_clk);
    @(negedge pcie_clk);
    if (rd_pending && fq.size() > 0) begin
      e = fq.pop_front();
      dout_data_valid = e.v;
      dout_tlast = e.last;
      dout_tkeep = e.keep;
      dout_tdata = e.data;
      if (e.v) real_pops++;
      if (lnk_mode2 && real_pops >= 2) user_lnk_up = 1'b0;
    end
    cyc++;
  endtask

  task automatic drain(input string name, input int max_cyc);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < max_cyc) begin
      tick();
      n++;
      if (fq.size() == 0 && !rd_pending && !pcie_tx_tvalid) done = 1'b1;
    end
    chk({name, "_drain_done"}, 64'(done), 64'd1);
  endtask

  task automatic cmp_pkt(input string name, input int v, input int beats);
    chk({name, "_beats"}, 64'(got.size()), 64'(beats));
    for (int i = 0; i < beats && i < got.size(); i++) begin
      chk({name, "_tdata"}, got[i].data, mk_data(v, i));
      chk({name, "_tkeep_tlast"}, {55'd0, got[i].last, got[i].keep},
          {55'd0, (i == beats - 1) ? 1'b1 : 1'b0, mk_keep(beats, i)});
    end
  endtask

  initial begin
    int rd0;
    int unstable;
    logic [63:0] held;
    bit held_ok;

    checks = 0; errors = 0; rd_cnt = 0; cyc = 0; real_pops = 0;
    first_rd = -1; first_v = -1; rd_pending = 1'b0; lnk_mode2 = 1'b0;
    exp_pkt = 0; exp_drop = 0;
    pcie_rst = 1'b1; empty = 1'b1; dout_data_valid = 1'b0; dout_tlast = 1'b0;
    dout_tkeep = 8'h00; dout_tdata = 64'd0; user_lnk_up = 1'b1; pcie_tx_tready = 1'b1;

    //              beats lnk bub tx drop
    tv[0] = '{2, 1, 1'b0, 1'b1, 0};  // MWr 3DW + 1DW, plain
    tv[1] = '{5, 1, 1'b1, 1'b1, 0};  // bubbles interleaved
    tv[2] = '{4, 0, 1'b0, 1'b0, 1};  // link down at first beat
    tv[3] = '{3, 1, 1'b0, 1'b1, 0};  // good packet after a drop
    tv[4] = '{1, 1, 1'b0, 1'b0, 1};  // malformed single beat
    tv[5] = '{1, 0, 1'b0, 1'b0, 1};  // link down single beat, stays IDLE
    tv[6] = '{2, 1, 1'b0, 1'b1, 0};  // proves IDLE after tv[5]
    tv[7] = '{4, 2, 1'b0, 1'b1, 0};  // link drops mid-packet, completes
    tv[8] = '{3, 1, 1'b1, 1'b1, 0};

    @(negedge pcie_clk);
    repeat (3) tick();
    chk("rst_tvalid", 64'(pcie_tx_tvalid), 64'd0);
    chk("rst_tlast", 64'(pcie_tx_tlast), 64'd0);
    chk("rst_tkeep", 64'(pcie_tx_tkeep), 64'd0);
    chk("rst_tdata", pcie_tx_tdata, 64'd0);
    chk("rst_tuser", 64'(pcie_tx_tuser), 64'd0);
    chk("rst_pkt_cnt", 64'(tx_pkt_cnt), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("rst_rd_en", 64'(rd_en), 64'd0);
    pcie_rst = 1'b0;
    tick();

    // Latency: tvalid two cycles after the first read strobe.
    got.delete();
    push_pkt(40, 2, 1'b0);
    first_rd = -1; first_v = -1;
    drain("lat", 50);
    chk("lat_rd_to_tvalid", 64'(first_v - first_rd), 64'd2);
    cmp_pkt("lat", 40, 2);
    exp_pkt += 1;
    chk("lat_pkt_cnt", 64'(tx_pkt_cnt), 64'(exp_pkt));

    // Table-driven packet scenarios.
    for (int v = 0; v < 9; v++) begin
      got.delete();
      user_lnk_up = (tv[v].lnk_mode != 0);
      lnk_mode2 = (tv[v].lnk_mode == 2);
      real_pops = 0;
      push_pkt(v, tv[v].beats, tv[v].bubbles);
      drain($sformatf("vec%0d", v), 200);
      lnk_mode2 = 1'b0;
      user_lnk_up = 1'b1;
      cmp_pkt($sformatf("vec%0d", v), v, tv[v].exp_tx ? tv[v].beats : 0);
      exp_pkt += tv[v].exp_tx ? 1 : 0;
      exp_drop += tv[v].exp_drop;
      chk($sformatf("vec%0d_pkt_cnt", v), 64'(tx_pkt_cnt), 64'(exp_pkt));
      chk($sformatf("vec%0d_drop_cnt", v), 64'(drop_cnt), 64'(exp_drop));
    end

    // Backpressure: 20 cycles of tready=0 over a 6-beat packet.
    got.delete();
    pcie_tx_tready = 1'b0;
    push_pkt(20, 6, 1'b0);
    rd0 = rd_cnt;
    unstable = 0;
    held_ok = 1'b0;
    held = 64'd0;
    repeat (20) begin
      tick();
      if (pcie_tx_tvalid) begin
        if (!held_ok) begin
          held = pcie_tx_tdata;
          held_ok = 1'b1;
        end else if (pcie_tx_tdata !== held) begin
          unstable++;
        end
      end
    end
    chk("bp_reads_while_stalled", 64'(rd_cnt - rd0), 64'd3);
    chk("bp_tvalid_held", 64'(pcie_tx_tvalid), 64'd1);
    chk("bp_head_tdata", held, mk_data(20, 0));
    chk("bp_tdata_unstable_cycles", 64'(unstable), 64'd0);
    chk("bp_no_handshake", 64'(got.size()), 64'd0);
    pcie_tx_tready = 1'b1;
    drain("bp", 100);
    cmp_pkt("bp", 20, 6);
    exp_pkt += 1;
    chk("bp_pkt_cnt", 64'(tx_pkt_cnt), 64'(exp_pkt));

    // Drop counter saturation.
    force dut.drop_cnt_q = 16'hFFFE;
    tick();
    release dut.drop_cnt_q;
    tick();
    chk("sat_preload", 64'(drop_cnt), 64'hFFFE);
    got.delete();
    push_pkt(50, 1, 1'b0);
    drain("sat1", 50);
    chk("sat_reach_max", 64'(drop_cnt), 64'hFFFF);
    push_pkt(51, 1, 1'b0);
    drain("sat2", 50);
    chk("sat_hold_max", 64'(drop_cnt), 64'hFFFF);
    chk("sat_no_tx", 64'(got.size()), 64'd0);

    // Reset with three beats queued mid-packet.
    pcie_tx_tready = 1'b0;
    push_pkt(30, 4, 1'b0);
    rd0 = rd_cnt;
    repeat (8) tick();
    chk("rstmid_queued_reads", 64'(rd_cnt - rd0), 64'd3);
    chk("rstmid_tvalid_before", 64'(pcie_tx_tvalid), 64'd1);
    fq.delete();
    pcie_rst = 1'b1;
    tick();
    chk("rstmid_tvalid_after", 64'(pcie_tx_tvalid), 64'd0);
    chk("rstmid_pkt_cnt", 64'(tx_pkt_cnt), 64'd0);
    chk("rstmid_drop_cnt", 64'(drop_cnt), 64'd0);
    pcie_rst = 1'b0;
    pcie_tx_tready = 1'b1;
    tick();
    got.delete();
    push_pkt(31, 3, 1'b0);
    drain("rstmid_post", 50);
    cmp_pkt("rstmid_post", 31, 3);
    chk("rstmid_post_pkt_cnt", 64'(tx_pkt_cnt), 64'd1);
    chk("rstmid_post_drop_cnt", 64'(drop_cnt), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo2pcie.md
Name: fifo2pcie

Overview:
- Reader/transmitter counterpart of the RX-side pcie2fifo path.
- Pops TLP beats from the TX TLP FIFO (standard-mode FIFO, read latency 1) and drives the 64-bit PCIe core TX AXI-stream.
- Discards bubble entries, drops malformed or link-down packets, and buffers beats in a 4-entry output queue so the PCIe core tready backpressure never loses data.
- Sits between the Eth decap / TX TLP FIFO and the PCIe hard-block s_axis_tx port.

Parameters:
- OBUF_DEPTH, 4, output queue entries; fixed at 4, other values unsupported.
- DROP_CNT_W, 16, width of the saturating drop counter.

Ports:
- pcie_clk  input  1  clock for all logic.
- pcie_rst  input  1  synchronous active-high reset.
- rd_en  output  1  FIFO read strobe; data appears on dout_* the next cycle.
- empty  input  1  FIFO empty.
- dout_data_valid  input  1  entry is a real beat; 0 marks a bubble entry.
- dout_tlast  input  1  last beat of TLP.
- dout_tkeep  input  8  byte enables.
- dout_tdata  input  64  TLP beat.
- user_lnk_up  input  1  PCIe link up.
- pcie_tx_tready  input  1  core ready.
- pcie_tx_tvalid  output  1  beat valid.
- pcie_tx_tlast  output  1  last beat.
- pcie_tx_tkeep  output  8  byte enables.
- pcie_tx_tdata  output  64  data.
- pcie_tx_tuser  output  4  driven constant 4'b0.
- tx_pkt_cnt  output  32  TLPs completed on TX; wraps.
- drop_cnt  output  DROP_CNT_W  dropped TLPs; saturates.

Behaviour:
- Reset values: rd_en 0; pcie_tx_tvalid/tlast 0; tkeep 0; tdata 0; counters 0; queue occupancy occ 0; pending-read flag pend 0; state IDLE.
- Read issue: rd_en = !empty && (occ + pend) <= 2, where occ is the registered queue occupancy.
  - pend <= rd_en every cycle.
  - When pend=1, dout_* is valid this cycle and is classified by the FSM.
  - Queue can never overflow; sustained throughput is 1 beat/cycle when tready is held high.
- Output queue: 4-entry FIFO of {tlast,tkeep,tdata}.
  - pcie_tx_tvalid = (occ != 0); head entry drives tx outputs.
  - Pop on tvalid && tready.
  - Push and pop in the same cycle leaves occ unchanged.
- Returned beat classification (only when pend=1):
  - dout_data_valid=0 (bubble): discarded in any state; no state change.
  - IDLE:
    - user_lnk_up=0 -> count drop; go to DRAIN, or stay IDLE if tlast=1.
    - dout_tlast=1 (1-beat TLP is malformed; minimum 3DW header needs 2 beats) -> discard and count drop.
    - Otherwise push beat and go to PKT.
  - PKT: push beat. tlast=1 -> IDLE. Link drop mid-packet does not abort; the packet is completed.
  - DRAIN: discard beat. tlast=1 -> IDLE.
- Counters:
  - tx_pkt_cnt += 1 on tvalid && tready && tlast.
  - drop_cnt += 1 per dropped packet, saturating at all-ones.
- Backpressure: while tready=0, outputs hold stable and reads continue until occ + pend reaches the limit.
- Reset mid-packet: queue and FSM cleared; tvalid deasserts the cycle after reset. A partial packet on the core interface is the core's responsibility.
- Latency: empty falling (with space and tready=1) -> rd_en same cycle -> push next cycle -> tvalid the cycle after (2 cycles).

Test Plan:
- MWr 3DW, 1 DW payload (2 beats, tkeep FF/FF) into FIFO, link up, tready=1 -> tvalid 2 cycles after rd_en; 2 beats out; tlast on beat 2; tx_pkt_cnt=1.
- Beats interleaved with bubble entries (data_valid=0) -> output identical, gap-free, no drops.
- tready=0 for 20 cycles during a 6-beat packet -> at most 4 queued; rd_en stalls; no loss or duplication; tdata order preserved after release.
- user_lnk_up=0 at first beat of a 4-beat packet, then a good packet -> first fully discarded; drop_cnt=1; second transmitted intact.
- Single-beat entry with tlast=1 in IDLE -> no tvalid; drop_cnt=1. Then force drop_cnt to 16'hFFFF and drop again -> stays 16'hFFFF.
- pcie_rst asserted mid-packet with occ=3 -> next cycle tvalid=0, occ=0, state IDLE; a subsequent packet transmits correctly.
